// File: rtl/regfile_sweep_if.sv
// Read/write port bundle for regfile_sweep: decode drives the read selects,
// writeback drives the write port; the register file answers on the slave side.
interface regfile_sweep_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic            we;
  logic [AW-1:0]   select_d;
  logic [XLEN-1:0] input_d;
  logic [AW-1:0]   select_a;
  logic [AW-1:0]   select_b;
  logic [XLEN-1:0] output_a;
  logic [XLEN-1:0] output_b;
  logic            ready;

  modport master (
    output we, select_d, input_d, select_a, select_b,
    input  output_a, output_b, ready
  );

  modport slave (
    input  we, select_d, input_d, select_a, select_b,
    output output_a, output_b, ready
  );
endinterface

// File: rtl/regfile_sweep.sv
// Parametrised integer register file: one write port, two combinational read
// ports, optional hardwired x0, write-to-read bypass, reset-triggered clear sweep.
module regfile_sweep #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic           clock,
  input  logic           reset,
  regfile_sweep_if.slave rf
);
  localparam int AW = $clog2(NREGS);

  localparam logic [0:0]  CLEAR = 1'b0;
  localparam logic [0:0]  RUN   = 1'b1;
  localparam logic [AW:0] LAST  = (AW+1)'(NREGS - 1);

  logic [0:0]      state;
  logic [AW:0]     clr_idx;
  logic [XLEN-1:0] mem [NREGS];

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else if (state == CLEAR) begin
      clr_idx <= clr_idx + (AW+1)'(1);
      if (clr_idx == LAST) state <= RUN;
    end
  end

  // Sweep and user writes share the single storage write port so the array
  // stays RAM-mappable; user writes are suppressed while reset is sampled.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = rf.select_d;
    wr_data = rf.input_d;
    if (state == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clr_idx[AW-1:0];
      wr_data = '0;
    end else if (!reset && rf.we && !(ZERO_REG != 0 && rf.select_d == '0)) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    rf.output_a = '0;
    if (state == RUN) begin
      if (ZERO_REG != 0 && rf.select_a == '0)
        rf.output_a = '0;
      else if (BYPASS != 0 && rf.we && rf.select_a == rf.select_d)
        rf.output_a = rf.input_d;
      else
        rf.output_a = mem[rf.select_a];
    end
  end

  always_comb begin
    rf.output_b = '0;
    if (state == RUN) begin
      if (ZERO_REG != 0 && rf.select_b == '0)
        rf.output_b = '0;
      else if (BYPASS != 0 && rf.we && rf.select_b == rf.select_d)
        rf.output_b = rf.input_d;
      else
        rf.output_b = mem[rf.select_b];
    end
  end

  assign rf.ready = (state == RUN);
endmodule

// File: tb/tb_regfile_sweep.sv
// Directed bench for regfile_sweep: default and no-zero/no-bypass 32x32 banks
// share stimulus; 64x16 and 8x2 banks get sweep-length and model-checked traffic.
module tb_regfile_sweep;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clock = ~clock;

  regfile_sweep_if #(.XLEN(32), .NREGS(32)) ifa ();
  regfile_sweep_if #(.XLEN(32), .NREGS(32)) ifb ();
  regfile_sweep_if #(.XLEN(64), .NREGS(16)) ifc ();
  regfile_sweep_if #(.XLEN(8),  .NREGS(2))  ifd ();

  assign ifb.we       = ifa.we;
  assign ifb.select_d = ifa.select_d;
  assign ifb.input_d  = ifa.input_d;
  assign ifb.select_a = ifa.select_a;
  assign ifb.select_b = ifa.select_b;

  regfile_sweep #(.XLEN(32), .NREGS(32), .ZERO_REG(1), .BYPASS(1))
    dut_a (.clock(clock), .reset(reset), .rf(ifa));
  regfile_sweep #(.XLEN(32), .NREGS(32), .ZERO_REG(0), .BYPASS(0))
    dut_b (.clock(clock), .reset(reset), .rf(ifb));
  regfile_sweep #(.XLEN(64), .NREGS(16), .ZERO_REG(1), .BYPASS(1))
    dut_c (.clock(clock), .reset(reset), .rf(ifc));
  regfile_sweep #(.XLEN(8),  .NREGS(2),  .ZERO_REG(1), .BYPASS(1))
    dut_d (.clock(clock), .reset(reset), .rf(ifd));

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle;
    ifa.we = 1'b0; ifa.select_d = '0; ifa.input_d = '0; ifa.select_a = '0; ifa.select_b = '0;
    ifc.we = 1'b0; ifc.select_d = '0; ifc.input_d = '0; ifc.select_a = '0; ifc.select_b = '0;
    ifd.we = 1'b0; ifd.select_d = '0; ifd.input_d = '0; ifd.select_a = '0; ifd.select_b = '0;
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    tick;
    reset = 1'b0;
  endtask

  // Counts not-ready cycles starting from the first CLEAR cycle, bounded.
  task automatic sweep_count(output int za, output int zb, output int zc, output int zd);
    za = 0; zb = 0; zc = 0; zd = 0;
    for (int i = 0; i < 100 && !ifa.ready; i++) begin
      #1;
      if (i == 5) check("clear_out_a", 64'(ifa.output_a), 64'h0);
      if (!ifb.ready) zb++;
      if (!ifc.ready) zc++;
      if (!ifd.ready) zd++;
      za++;
      tick;
    end
  endtask

  task automatic preload;
    for (int i = 0; i < 32; i++) begin
      ifa.we = 1'b1; ifa.select_d = 5'(i); ifa.input_d = 32'hA5A5_A5A5;
      tick;
    end
    ifa.we = 1'b0;
  endtask

  task automatic read_all_zero;
    for (int i = 0; i < 32; i++) begin
      ifa.select_a = 5'(i);
      ifa.select_b = 5'(31 - i);
      #1;
      check("zero_a_port_a", 64'(ifa.output_a), 64'h0);
      check("zero_a_port_b", 64'(ifa.output_b), 64'h0);
      check("zero_b_port_a", 64'(ifb.output_a), 64'h0);
      check("zero_b_port_b", 64'(ifb.output_b), 64'h0);
    end
  endtask

  initial begin
    int za, zb, zc, zd;
    logic [63:0] mc [16];
    logic [7:0]  md [2];
    logic        w;
    logic [3:0]  sdc, sac, sbc;
    logic [63:0] dc, ec;
    logic [0:0]  sdd, sad, sbd;
    logic [7:0]  dd, ed;

    foreach (mc[i]) mc[i] = '0;
    foreach (md[i]) md[i] = '0;
    idle;
    reset = 1'b1;
    tick;
    tick;
    #1;
    check("rst_ready", 64'(ifa.ready), 64'h0);
    check("rst_out_a", 64'(ifa.output_a), 64'h0);

    // writes attempted through the whole sweep must be lost
    ifa.we = 1'b1; ifa.select_d = 5'd3; ifa.input_d = 32'h55; ifa.select_a = 5'd3;
    reset = 1'b0;
    sweep_count(za, zb, zc, zd);
    check("sweep_len_a", 64'(za), 64'd32);
    check("sweep_len_b", 64'(zb), 64'd32);
    check("sweep_len_c", 64'(zc), 64'd16);
    check("sweep_len_d", 64'(zd), 64'd2);

    ifa.we = 1'b0;
    #1;
    check("clr_wr_a", 64'(ifa.output_a), 64'h0);
    check("clr_wr_b", 64'(ifb.output_a), 64'h0);
    ifa.we = 1'b1; ifa.input_d = 32'h77;
    #1;
    check("first_rdy_byp_a", 64'(ifa.output_a), 64'h77);
    check("first_rdy_nobyp_b", 64'(ifb.output_a), 64'h0);
    tick;
    ifa.we = 1'b0;
    #1;
    check("first_rdy_wr_a", 64'(ifa.output_a), 64'h77);
    check("first_rdy_wr_b", 64'(ifb.output_a), 64'h77);

    preload;
    ifa.select_a = 5'd9; ifa.select_b = 5'd0;
    #1;
    check("preload_a9", 64'(ifa.output_a), 64'hA5A5_A5A5);
    check("preload_a0", 64'(ifa.output_b), 64'h0);
    check("preload_b0", 64'(ifb.output_b), 64'hA5A5_A5A5);
    pulse_reset;
    sweep_count(za, zb, zc, zd);
    check("resweep_len_a", 64'(za), 64'd32);
    read_all_zero;

    preload;
    pulse_reset;
    repeat (9) tick;
    pulse_reset;
    sweep_count(za, zb, zc, zd);
    check("restart_len_a", 64'(za), 64'd32);
    check("restart_len_b", 64'(zb), 64'd32);
    read_all_zero;

    ifa.we = 1'b1; ifa.select_d = 5'd5; ifa.input_d = 32'h1234_5678;
    tick;
    ifa.we = 1'b0; ifa.select_a = 5'd5; ifa.select_b = 5'd5;
    #1;
    check("x5_port_a", 64'(ifa.output_a), 64'h1234_5678);
    check("x5_port_b", 64'(ifa.output_b), 64'h1234_5678);
    check("x5_b_port_a", 64'(ifb.output_a), 64'h1234_5678);
    ifa.we = 1'b1; ifa.select_d = 5'd31; ifa.input_d = 32'hFFFF_FFFF;
    tick;
    ifa.we = 1'b0; ifa.select_a = 5'd31; ifa.select_b = 5'd0;
    #1;
    check("x31_port_a", 64'(ifa.output_a), 64'hFFFF_FFFF);
    check("x0_nowrap_a", 64'(ifa.output_b), 64'h0);
    check("x0_nowrap_b", 64'(ifb.output_b), 64'h0);

    ifa.we = 1'b1; ifa.select_d = 5'd0; ifa.input_d = 32'hDEAD_BEEF; ifa.select_a = 5'd0;
    #1;
    check("x0_same_a", 64'(ifa.output_a), 64'h0);
    check("x0_same_b", 64'(ifb.output_a), 64'h0);
    tick;
    ifa.we = 1'b0;
    #1;
    check("x0_next_a", 64'(ifa.output_a), 64'h0);
    check("x0_next_b", 64'(ifb.output_a), 64'hDEAD_BEEF);

    ifa.we = 1'b1; ifa.select_d = 5'd7; ifa.input_d = 32'h1;
    tick;
    ifa.input_d = 32'h2; ifa.select_a = 5'd7; ifa.select_b = 5'd7;
    #1;
    check("byp_same_a", 64'(ifa.output_a), 64'h2);
    check("byp_same_a_pb", 64'(ifa.output_b), 64'h2);
    check("nobyp_same_b", 64'(ifb.output_a), 64'h1);
    tick;
    ifa.we = 1'b0;
    #1;
    check("byp_next_a", 64'(ifa.output_a), 64'h2);
    check("nobyp_next_b", 64'(ifb.output_a), 64'h2);

    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      sdc = 4'($urandom_range(0, 15));
      sac = 4'($urandom_range(0, 15));
      sbc = (i % 4 == 0) ? sdc : 4'($urandom_range(0, 15));
      dc = {$urandom(), $urandom()};
      ifc.we = w; ifc.select_d = sdc; ifc.input_d = dc; ifc.select_a = sac; ifc.select_b = sbc;
      #1;
      ec = (sac == 0) ? 64'h0 : (w && sac == sdc) ? dc : mc[sac];
      check("c_rand_a", ifc.output_a, ec);
      ec = (sbc == 0) ? 64'h0 : (w && sbc == sdc) ? dc : mc[sbc];
      check("c_rand_b", ifc.output_b, ec);
      tick;
      if (w && sdc != 0) mc[sdc] = dc;
    end
    ifc.we = 1'b0;

    for (int i = 0; i < 20; i++) begin
      w = 1'($urandom_range(0, 1));
      sdd = 1'($urandom_range(0, 1));
      sad = 1'($urandom_range(0, 1));
      sbd = 1'($urandom_range(0, 1));
      dd = 8'($urandom());
      ifd.we = w; ifd.select_d = sdd; ifd.input_d = dd; ifd.select_a = sad; ifd.select_b = sbd;
      #1;
      ed = (sad == 0) ? 8'h0 : (w && sad == sdd) ? dd : md[sad];
      check("d_rand_a", 64'(ifd.output_a), 64'(ed));
      ed = (sbd == 0) ? 8'h0 : (w && sbd == sdd) ? dd : md[sbd];
      check("d_rand_b", 64'(ifd.output_b), 64'(ed));
      tick;
      if (w && sdd != 0) md[sdd] = dd;
    end
    ifd.we = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
